// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared op-class and forward-select encodings for the hazard scheduler
package hazard_ctrl_pkg;

  // Op classes reported by the control unit for the ID-stage instruction
  localparam logic [1:0] OPT_NONE  = 2'b00;
  localparam logic [1:0] OPT_ALU   = 2'b01;
  localparam logic [1:0] OPT_LOAD  = 2'b10;
  localparam logic [1:0] OPT_STORE = 2'b11;

  // Operand source selects for the EX-stage operand muxes
  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  // Only ALU results and loads ever write a destination register
  function automatic logic opt_writes_rd(input logic [1:0] opt);
    return (opt == OPT_ALU) || (opt == OPT_LOAD);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage usage inputs and pipeline control outputs of the hazard scheduler
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int OPT_W  = 2
);

  logic              rs1use_ID;
  logic              rs2use_ID;
  logic [OPT_W-1:0]  hazard_optype_ID;
  logic [REG_AW-1:0] rd_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic              Branch_ID;

  logic              PC_EN_IF;
  logic              reg_FD_EN;
  logic              reg_FD_flush;
  logic              reg_DE_flush;
  logic [1:0]        forward_ctrl_A;
  logic [1:0]        forward_ctrl_B;
  logic              forward_ctrl_ls;

  // Pipeline side: presents the ID instruction, consumes the control outputs
  modport master (
    output rs1use_ID, rs2use_ID, hazard_optype_ID, rd_ID, rs1_ID, rs2_ID, Branch_ID,
    input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );

  // Hazard scheduler side
  modport slave (
    input  rs1use_ID, rs2use_ID, hazard_optype_ID, rd_ID, rs1_ID, rs2_ID, Branch_ID,
    output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );

endinterface

// File: rtl/hazard_stage_slot.sv
// rtl/hazard_stage_slot.sv - one registered shadow slot (rd, store rs2, optype) of the hazard scheduler
module hazard_stage_slot
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OPT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [OPT_W-1:0]  opt_i,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [OPT_W-1:0]  opt_o
);

  logic [REG_AW-1:0] rd_d,  rd_q;
  logic [REG_AW-1:0] rs2_d, rs2_q;
  logic [OPT_W-1:0]  opt_d, opt_q;

  // Next slot contents: a bubble is an empty op; rs2 is only meaningful for stores
  always_comb begin
    rd_d  = '0;
    rs2_d = '0;
    opt_d = OPT_NONE;
    if (!bubble) begin
      rd_d  = rd_i;
      opt_d = opt_i;
      if (opt_i == OPT_STORE) begin
        rs2_d = rs2_i;
      end
    end
  end

  // Slot register, cleared to an empty op on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      rs2_q <= '0;
      opt_q <= OPT_NONE;
    end else begin
      rd_q  <= rd_d;
      rs2_q <= rs2_d;
      opt_q <= opt_d;
    end
  end

  assign rd_o  = rd_q;
  assign rs2_o = rs2_q;
  assign opt_o = opt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forward selects, load-use stall and branch flush for the 5-stage RV32I pipe
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OPT_W  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int NSLOT = 3;
  localparam int S_EX  = 0;
  localparam int S_MEM = 1;
  localparam int S_WB  = 2;

  logic [REG_AW-1:0] slot_rd     [NSLOT];
  logic [REG_AW-1:0] slot_rs2    [NSLOT];
  logic [OPT_W-1:0]  slot_opt    [NSLOT];
  logic [REG_AW-1:0] nxt_rd      [NSLOT];
  logic [REG_AW-1:0] nxt_rs2     [NSLOT];
  logic [OPT_W-1:0]  nxt_opt     [NSLOT];
  logic              slot_bubble [NSLOT];

  logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;
  logic       ls_hit;

  // A live source matches a slot that produces a value into the same non-zero register
  function automatic logic src_hit(input logic src_use, input logic [REG_AW-1:0] src,
                                   input logic [OPT_W-1:0] opt, input logic [REG_AW-1:0] rd);
    return src_use && opt_writes_rd(opt) && (rd != '0) && (rd == src);
  endfunction

  // Youngest producer wins; a load still in EX cannot forward and is handled by the stall
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem,
                                          input logic [OPT_W-1:0] ex_opt,
                                          input logic [OPT_W-1:0] mem_opt);
    if (hit_ex && (ex_opt == OPT_ALU)) begin
      return FWD_EX;
    end else if (hit_mem && (mem_opt == OPT_ALU)) begin
      return FWD_MEM_ALU;
    end else if (hit_mem && (mem_opt == OPT_LOAD)) begin
      return FWD_MEM_LD;
    end
    return FWD_REG;
  endfunction

  // Shadow pipe inputs: EX takes the ID instruction (or a bubble on stall), later slots shift
  always_comb begin
    nxt_rd[S_EX]      = hz.rd_ID;
    nxt_rs2[S_EX]     = hz.rs2_ID;
    nxt_opt[S_EX]     = hz.hazard_optype_ID;
    slot_bubble[S_EX] = stall;
    for (int i = 1; i < NSLOT; i++) begin
      nxt_rd[i]      = slot_rd[i-1];
      nxt_rs2[i]     = slot_rs2[i-1];
      nxt_opt[i]     = slot_opt[i-1];
      slot_bubble[i] = 1'b0;
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    hazard_stage_slot #(
      .REG_AW (REG_AW),
      .OPT_W  (OPT_W)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (slot_bubble[g]),
      .rd_i   (nxt_rd[g]),
      .rs2_i  (nxt_rs2[g]),
      .opt_i  (nxt_opt[g]),
      .rd_o   (slot_rd[g]),
      .rs2_o  (slot_rs2[g]),
      .opt_o  (slot_opt[g])
    );
  end

  // Hazard detection; everything is masked while reset is held since slots may still be stale
  always_comb begin
    hit_ex_a  = src_hit(hz.rs1use_ID, hz.rs1_ID, slot_opt[S_EX],  slot_rd[S_EX]);
    hit_ex_b  = src_hit(hz.rs2use_ID, hz.rs2_ID, slot_opt[S_EX],  slot_rd[S_EX]);
    hit_mem_a = src_hit(hz.rs1use_ID, hz.rs1_ID, slot_opt[S_MEM], slot_rd[S_MEM]);
    hit_mem_b = src_hit(hz.rs2use_ID, hz.rs2_ID, slot_opt[S_MEM], slot_rd[S_MEM]);

    stall = rst_n && (hit_ex_a || hit_ex_b) && (slot_opt[S_EX] == OPT_LOAD);

    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (rst_n && !stall) begin
      fwd_a = fwd_pick(hit_ex_a, hit_mem_a, slot_opt[S_EX], slot_opt[S_MEM]);
      fwd_b = fwd_pick(hit_ex_b, hit_mem_b, slot_opt[S_EX], slot_opt[S_MEM]);
    end

    ls_hit = rst_n && (slot_opt[S_MEM] == OPT_STORE) && (slot_opt[S_WB] == OPT_LOAD) &&
             (slot_rd[S_WB] != '0) && (slot_rd[S_WB] == slot_rs2[S_MEM]);
  end

  // Pipeline register controls; a branch seen during a stall is retried next cycle
  always_comb begin
    hz.PC_EN_IF        = !stall;
    hz.reg_FD_EN       = !stall;
    hz.reg_DE_flush    = stall;
    hz.reg_FD_flush    = rst_n && hz.Branch_ID && !stall;
    hz.forward_ctrl_A  = fwd_a;
    hz.forward_ctrl_B  = fwd_b;
    hz.forward_ctrl_ls = ls_hit;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_en;
    logic       fd_en;
    logic       fd_flush;
    logic       de_flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ls;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t  exp_q[$];
  string tag_q[$];

  hazard_ctrl_if #(.REG_AW(5), .OPT_W(2)) hif ();

  hazard_ctrl #(.REG_AW(5), .OPT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic pc, input logic fde, input logic ffl, input logic dfl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic ls);
    exp_t e;
    e.pc_en = pc; e.fd_en = fde; e.fd_flush = ffl; e.de_flush = dfl;
    e.fa = fa; e.fb = fb; e.ls = ls;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Drive one ID instruction after the clock edge, queue its expectation, check at negedge
  task automatic step(input string tag, input logic rst, input logic u1, input logic [4:0] s1,
                      input logic u2, input logic [4:0] s2, input logic [1:0] op,
                      input logic [4:0] rd, input logic br, input exp_t e);
    exp_t  got_e;
    string t;
    @(posedge clk);
    #1;
    rst_n                = rst;
    hif.rs1use_ID        = u1;
    hif.rs1_ID           = s1;
    hif.rs2use_ID        = u2;
    hif.rs2_ID           = s2;
    hif.hazard_optype_ID = op;
    hif.rd_ID            = rd;
    hif.Branch_ID        = br;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got_e = exp_q.pop_front();
    t     = tag_q.pop_front();
    cmp({t, ".pc_en"},    {1'b0, hif.PC_EN_IF},        {1'b0, got_e.pc_en});
    cmp({t, ".fd_en"},    {1'b0, hif.reg_FD_EN},       {1'b0, got_e.fd_en});
    cmp({t, ".fd_flush"}, {1'b0, hif.reg_FD_flush},    {1'b0, got_e.fd_flush});
    cmp({t, ".de_flush"}, {1'b0, hif.reg_DE_flush},    {1'b0, got_e.de_flush});
    cmp({t, ".fwd_a"},    hif.forward_ctrl_A,          got_e.fa);
    cmp({t, ".fwd_b"},    hif.forward_ctrl_B,          got_e.fb);
    cmp({t, ".fwd_ls"},   {1'b0, hif.forward_ctrl_ls}, {1'b0, got_e.ls});
  endtask

  initial begin
    exp_t norm;
    exp_t stl;
    total = 0;
    bad   = 0;
    norm  = mk(1'b1, 1'b1, 1'b0, 1'b0, FWD_REG, FWD_REG, 1'b0);
    stl   = mk(1'b0, 1'b0, 1'b0, 1'b1, FWD_REG, FWD_REG, 1'b0);

    rst_n                = 1'b0;
    hif.rs1use_ID        = 1'b0;
    hif.rs1_ID           = '0;
    hif.rs2use_ID        = 1'b0;
    hif.rs2_ID           = '0;
    hif.hazard_optype_ID = OPT_NONE;
    hif.rd_ID            = '0;
    hif.Branch_ID        = 1'b0;

    // reset held two cycles with a live source
    step("rst1", 0, 1, 5'd5, 0, 5'd0, OPT_NONE, 5'd0, 0, norm);
    step("rst2", 0, 1, 5'd5, 0, 5'd0, OPT_NONE, 5'd0, 0, norm);
    step("empty", 1, 1, 5'd5, 1, 5'd5, OPT_NONE, 5'd0, 0, norm);

    // ALU producer, then EX and MEM consumers
    step("addi_x5", 1, 1, 5'd1, 0, 5'd0, OPT_ALU, 5'd5, 0, norm);
    step("use_ex",  1, 1, 5'd5, 1, 5'd2, OPT_ALU, 5'd9, 0,
         mk(1, 1, 0, 0, FWD_EX, FWD_REG, 0));
    step("use_mem", 1, 1, 5'd3, 1, 5'd5, OPT_ALU, 5'd10, 0,
         mk(1, 1, 0, 0, FWD_REG, FWD_MEM_ALU, 0));

    // load-use: one stall cycle, then load data forwarded from MEM
    step("lw_x6",    1, 1, 5'd2, 0, 5'd0, OPT_LOAD, 5'd6, 0, norm);
    step("lu_stall", 1, 1, 5'd4, 1, 5'd6, OPT_ALU, 5'd11, 0, stl);
    step("lu_fwd",   1, 1, 5'd4, 1, 5'd6, OPT_ALU, 5'd11, 0,
         mk(1, 1, 0, 0, FWD_REG, FWD_MEM_LD, 0));

    // x0 never forwards
    step("alu_x0", 1, 1, 5'd1, 0, 5'd0, OPT_ALU, 5'd0, 0, norm);
    step("use_x0", 1, 1, 5'd0, 1, 5'd0, OPT_NONE, 5'd0, 0, norm);

    // two writers of x7: EX copy wins; then sources pick different slots
    step("x7_a",    1, 0, 5'd0, 0, 5'd0, OPT_ALU, 5'd7, 0, norm);
    step("x7_b",    1, 0, 5'd0, 0, 5'd0, OPT_ALU, 5'd7, 0, norm);
    step("x7_use",  1, 1, 5'd7, 1, 5'd7, OPT_ALU, 5'd12, 0,
         mk(1, 1, 0, 0, FWD_EX, FWD_EX, 0));
    step("split",   1, 1, 5'd12, 1, 5'd7, OPT_NONE, 5'd0, 0,
         mk(1, 1, 0, 0, FWD_EX, FWD_MEM_ALU, 0));

    // store data forwarded from WB load
    step("lw_x8",   1, 1, 5'd2, 0, 5'd0, OPT_LOAD, 5'd8, 0, norm);
    step("sw_x8",   1, 1, 5'd2, 0, 5'd8, OPT_STORE, 5'd3, 0, norm);
    step("st_rd",   1, 1, 5'd3, 0, 5'd0, OPT_NONE, 5'd0, 0, norm);
    step("ls_fwd",  1, 0, 5'd0, 0, 5'd0, OPT_NONE, 5'd0, 0,
         mk(1, 1, 0, 0, FWD_REG, FWD_REG, 1));
    step("ls_off",  1, 0, 5'd0, 0, 5'd0, OPT_NONE, 5'd0, 0, norm);

    // branches: plain flush, then branch deferred by a load-use stall
    step("br",       1, 0, 5'd0, 0, 5'd0, OPT_NONE, 5'd0, 1,
         mk(1, 1, 1, 0, FWD_REG, FWD_REG, 0));
    step("lw_x9",    1, 0, 5'd0, 0, 5'd0, OPT_LOAD, 5'd9, 0, norm);
    step("br_stall", 1, 1, 5'd9, 0, 5'd0, OPT_NONE, 5'd0, 1, stl);
    step("br_retry", 1, 1, 5'd9, 0, 5'd0, OPT_NONE, 5'd0, 1,
         mk(1, 1, 1, 0, FWD_MEM_LD, FWD_REG, 0));

    // reset during a stall clears the shadow slots
    step("lw_x4",     1, 0, 5'd0, 0, 5'd0, OPT_LOAD, 5'd4, 0, norm);
    step("st_x4",     1, 1, 5'd4, 0, 5'd0, OPT_ALU, 5'd13, 0, stl);
    step("rst_mid",   0, 1, 5'd4, 0, 5'd0, OPT_ALU, 5'd13, 0, norm);
    step("post_rst",  1, 1, 5'd4, 0, 5'd0, OPT_ALU, 5'd13, 0, norm);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
